// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the five-stage pipeline (F, F/D, D/E, E/M, M/W).
// Latency: stall/flush/div/exc outputs are combinational from state and inputs; stall_cnt is registered.
// Backpressure: memory-not-ready holds F..M and bubbles W; a divide holds F..E until div_done.
// Ports: clk/rst (sync, active-high); hazard inputs load_use_d, branch_flush_d, div_e, div_done,
//        exception_m, i_stall, d_stall; per-stage stall_*/flush_*, div_start/div_cancel,
//        exc_redirect, state (RUN=0, DIV=1, EXC=2), stall_cnt (saturating stall_f cycle count).
module pipe_hazard_ctrl #(
    parameter int unsigned EXC_CYCLES = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_d,
    input  logic             branch_flush_d,
    input  logic             div_e,
    input  logic             div_done,
    input  logic             exception_m,
    input  logic             i_stall,
    input  logic             d_stall,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             stall_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             div_start,
    output logic             div_cancel,
    output logic             exc_redirect,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_DIV = 2'd1,
        ST_EXC = 2'd2
    } state_e;

    localparam logic [3:0] EXC_INIT = 4'(EXC_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       exc_cnt_q, exc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        stall_w      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_m      = 1'b0;
        flush_w      = 1'b0;
        div_start    = 1'b0;
        div_cancel   = 1'b0;
        exc_redirect = 1'b0;
        state_d      = state_q;
        exc_cnt_d    = exc_cnt_q;

        // Reset masks every control output; next state is irrelevant since the flops reset anyway.
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (exception_m) begin
                        // Exception beats memory stalls: the faulting path is discarded anyway.
                        flush_d      = 1'b1;
                        flush_e      = 1'b1;
                        flush_m      = 1'b1;
                        flush_w      = 1'b1;
                        exc_redirect = 1'b1;
                        div_cancel   = 1'b1;
                        state_d      = ST_EXC;
                        exc_cnt_d    = EXC_INIT;
                    end else if (i_stall || d_stall) begin
                        // Freeze F..M, push a bubble into W; lower-priority hazards wait.
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        stall_m = 1'b1;
                        flush_w = 1'b1;
                    end else if (div_e) begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_e   = 1'b1;
                        flush_m   = 1'b1;
                        div_start = 1'b1;
                        state_d   = ST_DIV;
                    end else if (load_use_d) begin
                        // Load-use wins over a branch redirect; the branch re-asserts next cycle.
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (branch_flush_d) begin
                        flush_d = 1'b1;
                    end
                end
                ST_DIV: begin
                    if (exception_m) begin
                        flush_d      = 1'b1;
                        flush_e      = 1'b1;
                        flush_m      = 1'b1;
                        flush_w      = 1'b1;
                        exc_redirect = 1'b1;
                        div_cancel   = 1'b1;
                        state_d      = ST_EXC;
                        exc_cnt_d    = EXC_INIT;
                    end else if (div_done && !i_stall) begin
                        // All enables open: E/M captures the quotient on this edge.
                        state_d = ST_RUN;
                    end else if (div_done) begin
                        // Result is held by the divider, so just wait out the fetch stall.
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        stall_m = 1'b1;
                        flush_w = 1'b1;
                    end else begin
                        // M carries a bubble during the divide, so d_stall has nothing to hold.
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end
                end
                ST_EXC: begin
                    flush_d = 1'b1;
                    if (exc_cnt_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        exc_cnt_d = exc_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            exc_cnt_q   <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exc_cnt_q <= exc_cnt_d;
            if (stall_f && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
// Latency: inputs change 1ns after posedge; combinational outputs are sampled on the negedge.
// Backpressure: n/a (bench).
module tb_pipe_hazard_ctrl;
    localparam int EXC = 2;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, load_use_d, branch_flush_d, div_e, div_done, exception_m, i_stall, d_stall;
    logic stall_f, stall_d, stall_e, stall_m, stall_w;
    logic flush_d, flush_e, flush_m, flush_w;
    logic div_start, div_cancel, exc_redirect;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;
    logic [11:0]   obs;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: mode 0=run, 1=dividing, 2=exception recovery.
    int m_mode = 0;
    int m_left = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.EXC_CYCLES(EXC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .load_use_d(load_use_d), .branch_flush_d(branch_flush_d),
        .div_e(div_e), .div_done(div_done), .exception_m(exception_m),
        .i_stall(i_stall), .d_stall(d_stall),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .flush_w(flush_w), .div_start(div_start), .div_cancel(div_cancel),
        .exc_redirect(exc_redirect), .state(state), .stall_cnt(stall_cnt)
    );

    assign obs = {stall_f, stall_d, stall_e, stall_m, stall_w,
                  flush_d, flush_e, flush_m, flush_w, div_start, div_cancel, exc_redirect};

    // Expected patterns, same bit order as obs.
    localparam logic [11:0] P_IDLE   = 12'b000000000000;
    localparam logic [11:0] P_LU     = 12'b110000100000;
    localparam logic [11:0] P_DIVGO  = 12'b111000010100;
    localparam logic [11:0] P_DIVW   = 12'b111000010000;
    localparam logic [11:0] P_MEM    = 12'b111100001000;
    localparam logic [11:0] P_EXC    = 12'b000001111011;
    localparam logic [11:0] P_EXCREC = 12'b000001000000;

    // Rule-level model: "hold" = how many leading stages (F,D,E,M) are frozen.
    function automatic void model(output logic [11:0] e, output int nmode, output int nleft,
                                  output int hold);
        logic fd, fe, fm, fw, ds, dc, er;
        hold = 0; fd = 0; fe = 0; fm = 0; fw = 0; ds = 0; dc = 0; er = 0;
        nmode = m_mode; nleft = m_left;
        if (rst) begin
            nmode = 0; nleft = 0;
        end else if (m_mode == 2) begin
            fd = 1;
            if (m_left == 0) nmode = 0; else nleft = m_left - 1;
        end else if (exception_m) begin
            fd = 1; fe = 1; fm = 1; fw = 1; er = 1; dc = 1; nmode = 2; nleft = EXC - 1;
        end else if (m_mode == 0) begin
            if (i_stall || d_stall) begin hold = 4; fw = 1; end
            else if (div_e) begin hold = 3; fm = 1; ds = 1; nmode = 1; end
            else if (load_use_d) begin hold = 2; fe = 1; end
            else if (branch_flush_d) fd = 1;
        end else begin
            if (div_done && !i_stall) nmode = 0;
            else if (div_done) begin hold = 4; fw = 1; end
            else begin hold = 3; fm = 1; end
        end
        e = {hold >= 1, hold >= 2, hold >= 3, hold >= 4, 1'b0, fd, fe, fm, fw, ds, dc, er};
    endfunction

    task automatic advance();
        logic [11:0] e;
        int nm, nl, h;
        model(e, nm, nl, h);
        @(posedge clk);
        m_mode = nm;
        m_left = nl;
        if (rst) m_cnt = 0;
        else if (h >= 1 && m_cnt < CMAX) m_cnt = m_cnt + 1;
        #1;
    endtask

    task automatic clear_inputs();
        load_use_d = 0; branch_flush_d = 0; div_e = 0; div_done = 0;
        exception_m = 0; i_stall = 0; d_stall = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        advance();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        load_use_d = 1; branch_flush_d = 1; div_e = 1; div_done = 1;
        exception_m = 1; i_stall = 1; d_stall = 1;
        for (int i = 0; i < 3; i++) begin
            advance();
            @(negedge clk);
            n_vec++; if (obs !== P_IDLE) begin n_bad++; $display("FAIL reset_out got %b want %b", obs, P_IDLE); end
            n_vec++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
            n_vec++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        end
        rst = 0;
        clear_inputs();
        @(negedge clk);
        n_vec++; if (obs !== P_IDLE) begin n_bad++; $display("FAIL release_out got %b want %b", obs, P_IDLE); end
        advance();
        @(negedge clk);
        n_vec++; if (state !== 2'd0 || stall_cnt !== '0) begin
            n_bad++; $display("FAIL release_state got st=%0d cnt=%0d want 0/0", state, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_use_d = 1; branch_flush_d = 1;
        @(negedge clk);
        n_vec++; if (obs !== P_LU) begin n_bad++; $display("FAIL lu_out got %b want %b", obs, P_LU); end
        advance();
        load_use_d = 0;
        @(negedge clk);
        n_vec++; if (obs !== P_EXCREC) begin n_bad++; $display("FAIL lu_branch got %b want %b", obs, P_EXCREC); end
        branch_flush_d = 0;
        @(negedge clk);
        n_vec++; if (obs !== P_IDLE) begin n_bad++; $display("FAIL lu_after got %b want %b", obs, P_IDLE); end
        n_vec++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
        advance();
    endtask

    task automatic test_divide();
        do_reset();
        div_e = 1;
        @(negedge clk);
        n_vec++; if (obs !== P_DIVGO) begin n_bad++; $display("FAIL div_start_out got %b want %b", obs, P_DIVGO); end
        advance();
        div_e = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_vec++; if (obs !== P_DIVW || state !== 2'd1) begin
                n_bad++; $display("FAIL div_wait%0d got %b st=%0d want %b st=1", i, obs, state, P_DIVW);
            end
            advance();
        end
        div_done = 1;
        @(negedge clk);
        n_vec++; if (obs !== P_IDLE || state !== 2'd1) begin
            n_bad++; $display("FAIL div_done_out got %b st=%0d want %b st=1", obs, state, P_IDLE);
        end
        advance();
        div_done = 0;
        @(negedge clk);
        n_vec++; if (state !== 2'd0 || stall_cnt !== 4'd6) begin
            n_bad++; $display("FAIL div_exit got st=%0d cnt=%0d want st=0 cnt=6", state, stall_cnt);
        end
    endtask

    task automatic test_div_istall();
        do_reset();
        div_e = 1;
        advance();
        div_e = 0; div_done = 1; i_stall = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++; if (obs !== P_MEM || state !== 2'd1) begin
                n_bad++; $display("FAIL divi_hold%0d got %b st=%0d want %b st=1", i, obs, state, P_MEM);
            end
            advance();
        end
        i_stall = 0;
        @(negedge clk);
        n_vec++; if (obs !== P_IDLE) begin n_bad++; $display("FAIL divi_release got %b want %b", obs, P_IDLE); end
        advance();
        div_done = 0;
        @(negedge clk);
        n_vec++; if (state !== 2'd0) begin n_bad++; $display("FAIL divi_exit got st=%0d want 0", state); end
    endtask

    task automatic test_exception();
        do_reset();
        exception_m = 1; d_stall = 1;
        @(negedge clk);
        n_vec++; if (obs !== P_EXC) begin n_bad++; $display("FAIL exc_out got %b want %b", obs, P_EXC); end
        advance();
        clear_inputs();
        exception_m = 1;  // must be ignored while recovering
        for (int i = 0; i < EXC; i++) begin
            @(negedge clk);
            n_vec++; if (obs !== P_EXCREC || state !== 2'd2) begin
                n_bad++; $display("FAIL exc_rec%0d got %b st=%0d want %b st=2", i, obs, state, P_EXCREC);
            end
            advance();
        end
        exception_m = 0;
        @(negedge clk);
        n_vec++; if (obs !== P_IDLE || state !== 2'd0) begin
            n_bad++; $display("FAIL exc_done got %b st=%0d want %b st=0", obs, state, P_IDLE);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        i_stall = 1;
        for (int k = 1; k <= 20; k++) begin
            advance();
            @(negedge clk);
            n_vec++; if (stall_cnt !== CW'((k < CMAX) ? k : CMAX)) begin
                n_bad++; $display("FAIL sat_cnt%0d got %0d want %0d", k, stall_cnt, (k < CMAX) ? k : CMAX);
            end
        end
        rst = 1;
        advance();
        @(negedge clk);
        n_vec++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL sat_reset got %0d want 0", stall_cnt); end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_random();
        logic [11:0] e;
        int nm, nl, h;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            exception_m    = ($urandom_range(0, 15) == 0);
            i_stall        = ($urandom_range(0, 4) == 0);
            d_stall        = ($urandom_range(0, 5) == 0);
            div_e          = ($urandom_range(0, 3) == 0);
            div_done       = ($urandom_range(0, 2) == 0);
            load_use_d     = ($urandom_range(0, 3) == 0);
            branch_flush_d = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            model(e, nm, nl, h);
            n_vec++; if (obs !== e) begin n_bad++; $display("FAIL rnd_out%0d got %b want %b", i, obs, e); end
            n_vec++; if (state !== 2'(m_mode)) begin n_bad++; $display("FAIL rnd_state%0d got %0d want %0d", i, state, m_mode); end
            n_vec++; if (stall_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt%0d got %0d want %0d", i, stall_cnt, m_cnt); end
            advance();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_divide();
        test_div_istall();
        test_exception();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline. It drives the enable/clear pair of every enable-and-clear pipeline register (F, F/D, D/E, E/M, M/W), with enable = ~stall_x and clear = flush_x. It resolves load-use, branch-flush, memory-wait, multi-cycle divide and exception events through a small FSM. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
EXC_CYCLES, 1, number of cycles spent in EXC after an exception (1..15)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-high
load_use_d  in  1  D-stage instr needs the load result in E
branch_flush_d  in  1  D-stage redirect; discard the instr in F/D
div_e  in  1  E-stage holds a DIV/DIVU
div_done  in  1  divider result valid; level, held until div_start is next pulsed or div_cancel
exception_m  in  1  M-stage exception detected
i_stall  in  1  instruction memory not ready
d_stall  in  1  data memory not ready
stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  hold the register (enable = ~stall)
flush_d, flush_e, flush_m, flush_w  out  1 each  clear the register to a bubble
div_start  out  1  one-cycle start pulse to the divider
div_cancel  out  1  abort the divider
exc_redirect  out  1  select the exception vector for the next PC
state  out  2  RUN=0, DIV=1, EXC=2
stall_cnt  out  CNT_W  cycles with stall_f=1, saturating at all-ones

Behaviour:
- All outputs are combinational from state and inputs, except stall_cnt, which is registered.
- rst high at a clock edge: state<=RUN, stall_cnt<=0, exc counter<=0.
- While rst is high, all stall/flush/div/exc outputs are forced to 0.
- Any output not listed in a row below is 0.

RUN, first matching row wins:
- 1. exception_m: flush_d=flush_e=flush_m=flush_w=1, exc_redirect=1, div_cancel=1. Next state EXC with counter=EXC_CYCLES-1. Memory stalls are ignored this cycle.
- 2. i_stall|d_stall: stall_f=stall_d=stall_e=stall_m=1, flush_w=1. Stay in RUN. Lower-priority events are re-evaluated once the stall drops.
- 3. div_e: stall_f=stall_d=stall_e=1, flush_m=1, div_start=1. Next state DIV.
- 4. load_use_d: stall_f=stall_d=1, flush_e=1.
- 5. branch_flush_d: flush_d=1.
- load_use_d and branch_flush_d together: row 4 wins. The branch is still in D next cycle and re-asserts.

DIV:
- exception_m (defensive only; M holds a bubble): same response as RUN row 1, next state EXC.
- div_done & ~i_stall: all stalls 0. The E/M register latches the result on this edge. Next state RUN. div_start=0.
- div_done & i_stall: stall_f..stall_m=1, flush_w=1. Stay in DIV (div_done remains held).
- otherwise: stall_f=stall_d=stall_e=1, flush_m=1. d_stall is ignored because M holds a bubble.

EXC:
- flush_d=1 each cycle; fetches are discarded while the PC redirects.
- Counter 0 -> RUN; else decrement.
- exception_m is ignored here, since all later stages are bubbles.

stall_cnt:
- Increments on each edge where stall_f=1 and rst=0.
- Holds at 2^CNT_W-1.

div_start:
- Never asserted in two consecutive cycles.
- Never asserted outside the RUN->DIV transition.

Test Plan:
- Reset: hold rst 3 cycles with all inputs at 1 -> all outputs 0, state=0, stall_cnt=0. Release with inputs at 0 -> still all 0.
- Load-use: pulse load_use_d 1 cycle -> stall_f=stall_d=1, flush_e=1 that cycle. Next cycle all 0. stall_cnt=1.
- Divide: div_e=1, div_done rises 5 cycles later -> div_start high 1 cycle. State=1 with stall_f/d/e=1 and flush_m=1 for 5 cycles. Cycle 6: all stalls 0, state=0. stall_cnt=6.
- Divide with i_stall coincident: div_done=1 and i_stall=1 for 2 cycles -> state stays 1 with stall_m=1 and flush_w=1. Exits to RUN the cycle i_stall drops.
- Exception vs memory stall: exception_m=1 and d_stall=1 together, EXC_CYCLES=2 -> flush_d/e/m/w=1, exc_redirect=1, div_cancel=1, stall_m=0. Then 2 cycles in EXC with flush_d=1, then RUN.
- Counter saturation (CNT_W=4): hold i_stall 20 cycles -> stall_cnt reaches 15 and stays there. rst -> 0.
